dmem_byte_lane_ctrl: RTL
========================

Name: dmem_byte_lane_ctrl

Overview:
Parametrised word-addressed data memory for the MIPS32 core. It adds byte-lane writes, a valid/ready request handshake, out-of-range fault reporting, and a sequential clear-on-reset state machine. The clear sequence replaces a single-cycle array wipe, so the storage can map to block RAM. It sits between the core's memory stage and the data array and accepts at most one request per cycle.

Parameters:
ADDR_BITS, 10, word-index width; DEPTH = 2**ADDR_BITS words of 32 bits.
CLEAR_ON_RESET, 1, 1 = zero every word after reset via the INIT sweep; 0 = enter READY directly and leave contents unchanged.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present this cycle.
req_ready  output  1  block can accept a request (state == READY), combinational.
address  input  30 ([31:2])  word address.
write_enable  input  1  1 = write, 0 = read.
byte_enable  input  4  write lane mask; bit i selects bits [8i+7:8i]; ignored on reads.
write_input  input  32  write data.
read_valid  output  1  read response valid (one-cycle pulse per accepted read).
read_result  output  32  read data; holds its value while read_valid = 0.
fault  output  1  one-cycle pulse: an accepted request addressed a word outside the array.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: read_valid = 0, fault = 0, read_result = 0, clear_ptr = 0. State = INIT if CLEAR_ON_RESET = 1, else READY.
- FSM state INIT:
  - req_ready = 0.
  - Each cycle: data[clear_ptr] <= 0, then clear_ptr increments.
  - The cycle that clears word DEPTH-1 transitions to READY.
  - The first cycle with reset low clears word 0; req_ready rises in cycle DEPTH+1 after reset deasserts.
- FSM state READY: req_ready = 1. No return to INIT except via reset.
- Accept: a request is accepted on a cycle where req_valid && req_ready. Requests presented while req_ready = 0 are ignored, with no response.
- In-range test: address[31:2+ADDR_BITS] == 0. The word index is address[2+ADDR_BITS-1:2].
- Accepted write, in range:
  - Each lane with byte_enable[i] = 1 is updated at the accepting edge; other lanes are unchanged.
  - byte_enable = 0 is a legal no-op.
  - No read_valid pulse.
- Accepted read, in range: on the next cycle, read_valid = 1 and read_result = the stored word. Latency is 1 and throughput is 1 per cycle.
- Accepted request, out of range:
  - The array is not modified.
  - Next cycle, fault = 1.
  - A faulting read also gives read_valid = 1 and read_result = 0.
- Read-after-write: a read of the same word accepted the cycle after a write returns the newly written data.
- Reset mid-operation: a response pending from the accepting edge is dropped, so read_valid = 0 and fault = 0 in the cycle after reset. Reset during INIT restarts the sweep at word 0.
- There are no X outputs under any condition.

Optional Feature:
DMEM_OUTPUT_REG_EN
- Defined:
  - read_valid, fault and read_result pass through one extra register stage, giving read latency 2.
  - Throughput stays 1 per cycle; req_ready is unchanged.
  - The extra stage resets to 0, and reset flushes both stages.
  - The read-after-write ordering guarantee is preserved.
- Undefined: latency is 1 as specified above.

Test Plan:
- Reset 1 cycle, ADDR_BITS = 4, CLEAR_ON_RESET = 1 -> req_ready = 0 for 16 cycles and 1 in cycle 17; a read of word 5 then returns 0 with read_valid one cycle later.
- Write 0xDEADBEEF to word 3 with byte_enable = 4'b1111, then write 0x000000AA with byte_enable = 4'b0001, then read word 3 -> read_result = 0xDEADBEAA.
- Back-to-back reads of words 1, 2, 3 (holding 0x11, 0x22, 0x33) on consecutive cycles -> read_valid high for 3 consecutive cycles with data 0x11, 0x22, 0x33.
- Read address 0x00000400 (word index 256, ADDR_BITS = 8) -> fault = 1, read_valid = 1, read_result = 0. A write to the same address -> fault = 1, read_valid = 0, and a subsequent sweep of all 256 words shows them unchanged.
- Assert reset for 1 cycle at sweep position 7 -> clearing restarts at word 0; req_ready rises exactly DEPTH+1 cycles after reset deasserts. Assert reset on a read's accepting edge -> no read_valid pulse follows.
- With DMEM_OUTPUT_REG_EN defined, repeat the back-to-back read test -> same data sequence delayed by one extra cycle, and read_result = 0 during the first 2 cycles after reset.

Source files
------------

// File: rtl/dmem_byte_lane_ctrl.sv
// Word-addressed 32-bit data memory: byte-lane writes, valid/ready requests, range faults, sequential clear.
// Optional `DMEM_OUTPUT_REG_EN adds a second response register stage (read latency 2).
module dmem_byte_lane_ctrl #(
    parameter int ADDR_BITS      = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:2] address,
    input  logic        write_enable,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_input,
    output logic        read_valid,
    output logic [31:0] read_result,
    output logic        fault
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {INIT, READY} state_t;

    state_t                 state;
    logic [ADDR_BITS-1:0]   clear_ptr;
    logic [31:0]            mem [DEPTH];
    logic                   accept;
    logic                   in_range;
    logic [ADDR_BITS-1:0]   idx;
    logic                   rv_q;
    logic                   flt_q;
    logic [31:0]            res_q;

    assign req_ready = (state == READY);
    assign accept    = req_valid && req_ready;
    assign in_range  = (address[31:2+ADDR_BITS] == '0);
    assign idx       = address[2+ADDR_BITS-1:2];

    always_ff @(posedge clock) begin
        if (reset) begin
            clear_ptr <= '0;
            if (CLEAR_ON_RESET) state <= INIT;
            else                state <= READY;
        end else if (state == INIT) begin
            clear_ptr <= clear_ptr + ADDR_BITS'(1);
            if (&clear_ptr) state <= READY;
        end
    end

    // No reset on the array so it can map to block RAM; the INIT sweep does the wipe.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[clear_ptr] <= '0;
        end else if (accept && write_enable && in_range) begin
            for (int i = 0; i < 4; i++)
                if (byte_enable[i]) mem[idx][8*i +: 8] <= write_input[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rv_q  <= 1'b0;
            flt_q <= 1'b0;
            res_q <= '0;
        end else begin
            rv_q  <= accept && !write_enable;
            flt_q <= accept && !in_range;
            // Result only moves on a read, so it holds between responses.
            if (accept && !write_enable) res_q <= in_range ? mem[idx] : '0;
        end
    end

`ifdef DMEM_OUTPUT_REG_EN
    logic        rv_q2;
    logic        flt_q2;
    logic [31:0] res_q2;

    always_ff @(posedge clock) begin
        if (reset) begin
            rv_q2  <= 1'b0;
            flt_q2 <= 1'b0;
            res_q2 <= '0;
        end else begin
            rv_q2  <= rv_q;
            flt_q2 <= flt_q;
            res_q2 <= res_q;
        end
    end

    assign read_valid  = rv_q2;
    assign fault       = flt_q2;
    assign read_result = res_q2;
`else
    assign read_valid  = rv_q;
    assign fault       = flt_q;
    assign read_result = res_q;
`endif

endmodule
